// File: rtl/pb_pkg.sv
// Shared push-button types and timing constants for the emulator and its debouncer.
// The default press and gap widths are chosen to comfortably exceed the debounce window.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } pb_tx_state_t;

    localparam int DEBOUNCE_CYCLES      = 2**20;
    localparam int DEFAULT_PRESS_CYCLES = 1_100_000;
    localparam int DEFAULT_LONG_CYCLES  = 4_400_000;
    localparam int DEFAULT_GAP_CYCLES   = 1_100_000;
    localparam int DEFAULT_CNT_W        = 23;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

endpackage

// File: rtl/pb_cmd_fifo.sv
// One-bit-wide command queue (bit = long press) for the push-button emulator.
// flush empties the queue and overrides any push or pop in the same cycle.
module pb_cmd_fifo
    import pb_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pb_press_emulator.sv
// Turns queued short/long press commands into timed active-low pulses on pb_n,
// with an enforced high gap after every release so each command is seen exactly once.
module pb_press_emulator
    import pb_pkg::*;
#(
    parameter int PRESS_CYCLES = DEFAULT_PRESS_CYCLES,
    parameter int LONG_CYCLES  = DEFAULT_LONG_CYCLES,
    parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_long,
    output logic cmd_ready,
    input  logic abort,
    output logic pb_n,
    output logic press_start,
    output logic press_end,
    output logic busy
);

    localparam longint CNT_SPAN = longint'(1) << CNT_W;

    if (PRESS_CYCLES < 1 || longint'(PRESS_CYCLES) > CNT_SPAN ||
        LONG_CYCLES  < 1 || longint'(LONG_CYCLES)  > CNT_SPAN ||
        GAP_CYCLES   < 1 || longint'(GAP_CYCLES)   > CNT_SPAN) begin : g_bad_timing
        $error("pb_press_emulator: timing parameters must be in 1..2**CNT_W");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pb_press_emulator: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    pb_tx_state_t     state;
    pb_tx_state_t     state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic             pb_n_next;
    logic             press_start_next;
    logic             press_end_next;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    // A command offered alongside abort is dropped together with the flushed queue.
    assign cmd_ready = ~fifo_full;
    assign fifo_push = cmd_valid & cmd_ready & ~abort;
    assign busy      = (state != IDLE) | ~fifo_empty;

    pb_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .flush(abort),
        .din  (cmd_long),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            pb_n        <= 1'b1;
            press_start <= 1'b0;
            press_end   <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            pb_n        <= pb_n_next;
            press_start <= press_start_next;
            press_end   <= press_end_next;
        end
    end

    // abort outranks the IDLE pop and cuts a press short; in GAP it has no effect on timing.
    always_comb begin
        state_next       = state;
        timer_next       = timer;
        pb_n_next        = pb_n;
        press_start_next = 1'b0;
        press_end_next   = 1'b0;
        fifo_pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && !fifo_empty) begin
                    fifo_pop         = 1'b1;
                    timer_next       = fifo_dout ? LONG_LOAD : PRESS_LOAD;
                    pb_n_next        = 1'b0;
                    press_start_next = 1'b1;
                    state_next       = PRESS;
                end
            end
            PRESS: begin
                if (abort || timer == '0) begin
                    pb_n_next      = 1'b1;
                    press_end_next = 1'b1;
                    timer_next     = GAP_LOAD;
                    state_next     = GAP;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            GAP: begin
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
                pb_n_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pb_press_emulator.sv
// Directed self-checking bench for pb_press_emulator with short timing (8/20/5, depth 4).
// "Cycle k" is the sample taken 1 time unit after the k-th rising edge of a test.
module tb_pb_press_emulator;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_long = 1'b0;
    logic abort = 1'b0;
    logic cmd_ready;
    logic pb_n;
    logic press_start;
    logic press_end;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    pb_press_emulator #(
        .PRESS_CYCLES(8),
        .LONG_CYCLES (20),
        .GAP_CYCLES  (5),
        .CNT_W       (5),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_long   (cmd_long),
        .cmd_ready  (cmd_ready),
        .abort      (abort),
        .pb_n       (pb_n),
        .press_start(press_start),
        .press_end  (press_end),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        cmd_long  = 1'b0;
        abort     = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        reset     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({pb_n, cmd_ready, busy, press_start, press_end} !== 5'b11000) begin
                n_err++;
                $display("[TB] FAIL reset c=%0d got pb_n/ready/busy/ps/pe=%b want 11000", c,
                         {pb_n, cmd_ready, busy, press_start, press_end});
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_short();
        logic [2:0] exp_v;
        do_reset();
        cmd_valid = 1'b1;
        cmd_long  = 1'b0;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({pb_n, busy} !== 2'b11) begin
            n_err++;
            $display("[TB] FAIL short_c0 got pb_n/busy=%b want 11", {pb_n, busy});
        end
        for (int c = 1; c <= 24; c++) begin
            tick();
            exp_v = {(c >= 1 && c <= 8) ? 1'b0 : 1'b1, c == 1, c == 9};
            n_cmp++;
            if ({pb_n, press_start, press_end} !== exp_v) begin
                n_err++;
                $display("[TB] FAIL short_wave c=%0d got pb_n/ps/pe=%b want %b", c,
                         {pb_n, press_start, press_end}, exp_v);
            end
            if (c <= 13 || c >= 15) begin
                n_cmp++;
                if (busy !== (c <= 13)) begin
                    n_err++;
                    $display("[TB] FAIL short_busy c=%0d got %b want %b", c, busy, c <= 13);
                end
            end
        end
    endtask

    task automatic test_long_then_short();
        logic exp_pb;
        do_reset();
        cmd_valid = 1'b1;
        cmd_long  = 1'b1;
        tick();
        cmd_long = 1'b0;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (pb_n !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL long_start c=1 got pb_n=%b want 0", pb_n);
        end
        for (int c = 2; c <= 45; c++) begin
            tick();
            exp_pb = !((c >= 1 && c <= 20) || (c >= 27 && c <= 34));
            n_cmp++;
            if (pb_n !== exp_pb) begin
                n_err++;
                $display("[TB] FAIL long_wave c=%0d got pb_n=%b want %b", c, pb_n, exp_pb);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL long_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ready_seen;
        int accepted;
        int starts;
        int lows;
        do_reset();
        accepted  = 0;
        starts    = 0;
        lows      = 0;
        cmd_long  = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ready_seen[i] = cmd_ready;
            if (cmd_ready) accepted++;
            tick();
            if (press_start) starts++;
            if (!pb_n) lows++;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (ready_seen !== 6'b011111) begin
            n_err++;
            $display("[TB] FAIL b2b_ready got %b want 011111 (bit0 = first edge)", ready_seen);
        end
        n_cmp++;
        if (accepted !== 5) begin
            n_err++;
            $display("[TB] FAIL b2b_accepted got %0d want 5", accepted);
        end
        for (int c = 0; c < 100; c++) begin
            tick();
            if (press_start) starts++;
            if (!pb_n) lows++;
            n_cmp++;
            if ((press_start & press_end) !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL b2b_pulse_overlap c=%0d got ps=%b pe=%b", c, press_start, press_end);
            end
        end
        n_cmp++;
        if (starts !== 5) begin
            n_err++;
            $display("[TB] FAIL b2b_presses got %0d want 5", starts);
        end
        n_cmp++;
        if (lows !== 40) begin
            n_err++;
            $display("[TB] FAIL b2b_low_cycles got %0d want 40", lows);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort_press();
        int starts;
        do_reset();
        starts    = 0;
        cmd_long  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        tick();
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (pb_n !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_pre c=4 got pb_n=%b want 0", pb_n);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({pb_n, press_end, press_start, busy, cmd_ready} !== 5'b11011) begin
            n_err++;
            $display("[TB] FAIL abort_c5 got pb_n/pe/ps/busy/ready=%b want 11011",
                     {pb_n, press_end, press_start, busy, cmd_ready});
        end
        for (int c = 6; c <= 40; c++) begin
            tick();
            if (press_start) starts++;
            n_cmp++;
            if ({pb_n, busy} !== {1'b1, c <= 9}) begin
                n_err++;
                $display("[TB] FAIL abort_gap c=%0d got pb_n/busy=%b want %b", c,
                         {pb_n, busy}, {1'b1, c <= 9});
            end
        end
        n_cmp++;
        if (starts !== 0) begin
            n_err++;
            $display("[TB] FAIL abort_no_press got %0d presses want 0", starts);
        end
    endtask

    task automatic test_abort_gap_drop();
        int starts;
        do_reset();
        starts    = 0;
        cmd_long  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        abort     = 1'b1;
        cmd_valid = 1'b1;
        tick();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        for (int c = 12; c <= 30; c++) begin
            tick();
            if (press_start) starts++;
            if (c == 13 || c == 14) begin
                n_cmp++;
                if (busy !== (c == 13)) begin
                    n_err++;
                    $display("[TB] FAIL abort_gap_busy c=%0d got %b want %b", c, busy, c == 13);
                end
            end
        end
        n_cmp++;
        if (starts !== 0) begin
            n_err++;
            $display("[TB] FAIL abort_drop got %0d presses want 0", starts);
        end
    endtask

    task automatic test_reset_mid_press();
        int starts;
        do_reset();
        starts    = 0;
        cmd_long  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (pb_n !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rst_mid_pre c=3 got pb_n=%b want 0", pb_n);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({pb_n, busy, cmd_ready, press_start, press_end} !== 5'b10100) begin
            n_err++;
            $display("[TB] FAIL rst_mid c=4 got pb_n/busy/ready/ps/pe=%b want 10100",
                     {pb_n, busy, cmd_ready, press_start, press_end});
        end
        for (int c = 5; c <= 30; c++) begin
            tick();
            if (press_start || !pb_n) starts++;
        end
        n_cmp++;
        if (starts !== 0) begin
            n_err++;
            $display("[TB] FAIL rst_mid_queue got %0d low/start cycles want 0", starts);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_short();
        test_long_then_short();
        test_back_to_back();
        test_abort_press();
        test_abort_gap_drop();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
